dpr_sync_be: RTL and testbench

Parametrised synchronous dual-port RAM: one write port and one read port on a single clock. It extends the basic dual-port RAM with per-byte write enables, a selectable read-during-write policy, a configurable read latency of 1 or 2 cycles, a read-valid strobe, collision reporting and out-of-range address detection. It is a drop-in storage block for FIFOs, line buffers and register-file style structures: block-select gating and reset semantics match the existing RAM.

---
 rtl/dpr_sync_be.sv | 124 ++++++++++++
 tb/tb_dpr_sync_be.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dpr_sync_be.sv
// Synchronous dual-port RAM with per-byte write enables, selectable read-during-write
// policy, 1- or 2-cycle read latency, read-valid strobe, collision and address-error flags.
module dpr_sync_be #(
  parameter  int MEM_WIDTH  = 16,
  parameter  int MEM_DEPTH  = 1024,
  parameter  int ADDR_SIZE  = 10,
  parameter  int BYTE_W     = 8,
  parameter  int RDW_MODE   = 0,
  parameter  int RD_LATENCY = 1,
  localparam int NB         = MEM_WIDTH / BYTE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 blk_select,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] add_wr,
  input  logic [MEM_WIDTH-1:0] din,
  input  logic [NB-1:0]        wr_be,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] add_rd,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 rd_valid,
  output logic                 collision,
  output logic                 addr_err
);

  localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE+1)'(MEM_DEPTH);

  logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                 w_wr_acc, w_rd_acc, w_wr_in, w_rd_in;
  logic                 w_wr_ok, w_wr_err, w_rd_err, w_coll;
  logic [MEM_WIDTH-1:0] w_old, w_merge, w_rd_data;

  logic                 w_p_valid, w_p_coll, w_p_err;
  logic [MEM_WIDTH-1:0] w_p_data;

  logic [MEM_WIDTH-1:0] r_dout;
  logic                 r_valid, r_coll, r_rd_err, r_wr_err;

  assign w_wr_acc  = !rst && blk_select && wr_en;
  assign w_rd_acc  = !rst && blk_select && rd_en;
  assign w_wr_in   = ({1'b0, add_wr} < DEPTH_L);
  assign w_rd_in   = ({1'b0, add_rd} < DEPTH_L);
  assign w_wr_ok   = w_wr_acc && w_wr_in;
  assign w_wr_err  = w_wr_acc && !w_wr_in;
  assign w_rd_err  = w_rd_acc && !w_rd_in;
  assign w_coll    = w_rd_acc && w_rd_in && w_wr_ok && (add_rd == add_wr);
  assign w_old     = w_rd_in ? r_mem[add_rd] : '0;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_merge = w_old;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) w_merge[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
    end
  end

  assign w_rd_data = (RDW_MODE == 1 && w_coll) ? w_merge : w_old;

  // NOTE: the storage array has no reset; contents survive rst and only lanes enabled by wr_be change.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) r_mem[add_wr][i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Optional first read stage; flags ride along with the data so they stay aligned.
  if (RD_LATENCY == 2) begin : g_lat2
    logic [MEM_WIDTH-1:0] r_s1_data;
    logic                 r_s1_valid, r_s1_coll, r_s1_err;

    // NOTE: sequential state is always assigned with <= so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1_valid <= 1'b0;
        r_s1_coll  <= 1'b0;
        r_s1_err   <= 1'b0;
      end else begin
        r_s1_valid <= w_rd_acc;
        r_s1_coll  <= w_coll;
        r_s1_err   <= w_rd_err;
      end
    end

    always_ff @(posedge clk) begin
      if (w_rd_acc) r_s1_data <= w_rd_data;
    end

    assign w_p_valid = r_s1_valid;
    assign w_p_coll  = r_s1_coll;
    assign w_p_err   = r_s1_err;
    assign w_p_data  = r_s1_data;
  end else begin : g_lat1
    assign w_p_valid = w_rd_acc;
    assign w_p_coll  = w_coll;
    assign w_p_err   = w_rd_err;
    assign w_p_data  = w_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_coll   <= 1'b0;
      r_rd_err <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_valid  <= w_p_valid;
      r_coll   <= w_p_valid && w_p_coll;
      r_rd_err <= w_p_valid && w_p_err;
      r_wr_err <= w_wr_err;
      if (w_p_valid) r_dout <= w_p_data;
    end
  end

  assign dout      = r_dout;
  assign rd_valid  = r_valid;
  assign collision = r_coll;
  assign addr_err  = r_wr_err | r_rd_err;

endmodule

// File: tb/tb_dpr_sync_be.sv
// Directed bench: two RAM instances share stimulus; A is old-data/latency-1, B is
// write-through/latency-2, both with 1000 words so the out-of-range path is reachable.
module tb_dpr_sync_be;

  logic        clk = 1'b0;
  logic        rst, blk_select, wr_en, rd_en;
  logic [9:0]  add_wr, add_rd;
  logic [15:0] din;
  logic [1:0]  wr_be;

  logic [15:0] dout_a, dout_b;
  logic        valid_a, valid_b, coll_a, coll_b, err_a, err_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dpr_sync_be #(.MEM_WIDTH(16), .MEM_DEPTH(1000), .ADDR_SIZE(10), .BYTE_W(8),
                .RDW_MODE(0), .RD_LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .blk_select(blk_select), .wr_en(wr_en), .add_wr(add_wr),
    .din(din), .wr_be(wr_be), .rd_en(rd_en), .add_rd(add_rd),
    .dout(dout_a), .rd_valid(valid_a), .collision(coll_a), .addr_err(err_a));

  dpr_sync_be #(.MEM_WIDTH(16), .MEM_DEPTH(1000), .ADDR_SIZE(10), .BYTE_W(8),
                .RDW_MODE(1), .RD_LATENCY(2)) u_b (
    .clk(clk), .rst(rst), .blk_select(blk_select), .wr_en(wr_en), .add_wr(add_wr),
    .din(din), .wr_be(wr_be), .rd_en(rd_en), .add_rd(add_rd),
    .dout(dout_b), .rd_valid(valid_b), .collision(coll_b), .addr_err(err_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; add_wr = a; din = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  // Read a; A reports after one edge, B after two. Any write set up by the caller shares the cycle.
  task automatic do_read(input string tag, input logic [9:0] a, input logic [15:0] ea,
                         input logic [15:0] eb, input logic ca, input logic cb, input logic ee);
    rd_en = 1'b1; add_rd = a;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check({tag, " A dout"},  dout_a,  ea);
    check({tag, " A valid"}, valid_a, 1'b1);
    check({tag, " A coll"},  coll_a,  ca);
    check({tag, " A aerr"},  err_a,   ee);
    check({tag, " B early valid"}, valid_b, 1'b0);
    check({tag, " B early aerr"},  err_b,   1'b0);
    tick();
    check({tag, " B dout"},  dout_b,  eb);
    check({tag, " B valid"}, valid_b, 1'b1);
    check({tag, " B coll"},  coll_b,  cb);
    check({tag, " B aerr"},  err_b,   ee);
    check({tag, " A late valid"}, valid_a, 1'b0);
    check({tag, " A late aerr"},  err_a,   1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] last_a, last_b;
    logic        ev;
    int          nv_b;

    // Reset with live requests that must be ignored.
    rst = 1'b1; blk_select = 1'b1; wr_en = 1'b1; add_wr = 10'd3; din = 16'hDEAD;
    wr_be = 2'b11; rd_en = 1'b1; add_rd = 10'd3;
    tick();
    tick();
    check("rst A dout",  dout_a,  16'h0);
    check("rst A valid", valid_a, 1'b0);
    check("rst B dout",  dout_b,  16'h0);
    check("rst B valid", valid_b, 1'b0);
    check("rst A aerr",  err_a,   1'b0);
    check("rst B coll",  coll_b,  1'b0);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    tick();
    check("post-rst A valid", valid_a, 1'b0);
    check("post-rst B valid", valid_b, 1'b0);

    // Basic access.
    wr(10'd3, 16'hA5A5, 2'b11);
    do_read("basic", 10'd3, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    check("hold A dout", dout_a, 16'hA5A5);

    // Byte enables.
    wr(10'd7, 16'h1234, 2'b11);
    wr(10'd7, 16'hABCD, 2'b01);
    do_read("be01", 10'd7, 16'h12CD, 16'h12CD, 1'b0, 1'b0, 1'b0);
    wr(10'd7, 16'hABCD, 2'b00);
    do_read("be00", 10'd7, 16'h12CD, 16'h12CD, 1'b0, 1'b0, 1'b0);

    // Collision: A returns old data, B returns merged word.
    wr(10'd5, 16'h1111, 2'b11);
    wr_en = 1'b1; add_wr = 10'd5; din = 16'h2222; wr_be = 2'b10;
    do_read("coll", 10'd5, 16'h1111, 16'h2211, 1'b1, 1'b1, 1'b0);
    do_read("after coll", 10'd5, 16'h2211, 16'h2211, 1'b0, 1'b0, 1'b0);

    // Streaming with blk_select low for the read of address 3.
    for (int a = 0; a < 8; a++) wr(10'(a), 16'h0100 + 16'(a), 2'b11);
    last_a = 16'h2211; last_b = 16'h2211; nv_b = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        blk_select = (k != 3); rd_en = 1'b1; add_rd = 10'(k);
      end else begin
        blk_select = 1'b1; rd_en = 1'b0;
      end
      tick();
      ev = (k < 8) && (k != 3);
      if (ev) last_a = 16'h0100 + 16'(k);
      check($sformatf("stream A valid k=%0d", k), valid_a, ev);
      check($sformatf("stream A dout k=%0d", k),  dout_a,  last_a);
      ev = (k >= 1) && (k != 4);
      if (ev) last_b = 16'h0100 + 16'(k - 1);
      if (valid_b) nv_b++;
      check($sformatf("stream B valid k=%0d", k), valid_b, ev);
      check($sformatf("stream B dout k=%0d", k),  dout_b,  last_b);
    end
    tick();
    check("stream B tail valid", valid_b, 1'b0);
    check("stream B pulses", 32'(nv_b), 32'd7);

    // Out-of-range write and read.
    wr(10'd0,   16'h0AAA, 2'b11);
    wr(10'd999, 16'h0999, 2'b11);
    wr(10'd1000, 16'hFFFF, 2'b11);
    check("oob wr A aerr", err_a, 1'b1);
    check("oob wr B aerr", err_b, 1'b1);
    tick();
    check("oob wr A aerr clear", err_a, 1'b0);
    check("oob wr B aerr clear", err_b, 1'b0);
    do_read("oob rd", 10'd1000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    do_read("addr0",   10'd0,   16'h0AAA, 16'h0AAA, 1'b0, 1'b0, 1'b0);
    do_read("addr999", 10'd999, 16'h0999, 16'h0999, 1'b0, 1'b0, 1'b0);

    // Reset while a read is in B's pipeline.
    wr(10'd9, 16'h5555, 2'b11);
    rd_en = 1'b1; add_rd = 10'd9;
    tick();
    rd_en = 1'b0;
    check("midrst A dout", dout_a, 16'h5555);
    rst = 1'b1;
    tick();
    check("midrst B valid", valid_b, 1'b0);
    check("midrst B dout",  dout_b,  16'h0);
    check("midrst A dout0", dout_a,  16'h0);
    rst = 1'b0;
    tick();
    check("midrst B valid +1", valid_b, 1'b0);
    tick();
    check("midrst B valid +2", valid_b, 1'b0);
    check("midrst B dout +2",  dout_b,  16'h0);
    do_read("retained", 10'd9, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
